out_port_uart_tx: RTL and testbench

Downstream consumer of the datapath's output port. Captures 32-bit words that the datapath writes with an `out` instruction into a small FIFO. Transmits each word as four 8N1 UART bytes, least-significant byte first, on a single serial line. This decouples the single-cycle port write from the much slower serial link, and reports backpressure and overflow status back to the control side.

---
 rtl/out_port_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_out_port_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: word FIFO plus 8N1 UART serializer for the datapath
// output port. Each 32-bit word goes out as four bytes, LSB byte first.
// Optional build macro OUT_UART_PARITY_EN adds an even-parity bit per byte.
// Ports: clk, clr (sync active-high reset), out_wr/out_data (port write),
//        tx (serial line, idle high), full, busy, overflow (sticky),
//        words_pending (FIFO occupancy).
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        out_wr,
    input  logic [31:0]                 out_data,
    output logic                        tx,
    output logic                        full,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] words_pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [15:0]   LAST_CLK = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef OUT_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    logic [2:0]    state;
    logic [15:0]   clk_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shreg;

    logic          wr_ok;
    logic          pop;
    logic          bit_end;
    logic [7:0]    cur_byte;
    logic [2:0]    nxt_bit;

    // Acceptance uses registered occupancy, so a same-edge pop never frees a slot.
    assign wr_ok    = out_wr && (occ < DEPTH_V);
    assign pop      = (state == IDLE) && (occ != '0);
    assign bit_end  = (clk_cnt == LAST_CLK);
    assign cur_byte = shreg[7:0];
    assign nxt_bit  = bit_idx + 3'd1;

    assign full          = (occ == DEPTH_V);
    assign busy          = (state != IDLE) || (occ != '0);
    assign words_pending = occ;

    always_ff @(posedge clk) begin
        if (wr_ok && !clr)
            mem[wr_ptr] <= out_data;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (out_wr && !wr_ok)
                overflow <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // tx is registered: each transition loads the level of the next bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            tx       <= 1'b1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        byte_idx <= '0;
                        clk_cnt  <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                            tx    <= ^cur_byte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= nxt_bit;
                            tx      <= cur_byte[nxt_bit];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef OUT_UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            shreg    <= {8'h00, shreg[31:8]};
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx: directed bench for out_port_uart_tx.
// A negedge UART decoder pops expected bytes from a scoreboard queue.
module tb_out_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (40 + 4 * P) * CPB;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        out_wr = 1'b0;
    logic [31:0] out_data = '0;
    logic        tx;
    logic        full;
    logic        busy;
    logic        overflow;
    logic [2:0]  words_pending;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] expq[$];

    always #5 clk = ~clk;

    out_port_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .out_wr       (out_wr),
        .out_data     (out_data),
        .tx           (tx),
        .full         (full),
        .busy         (busy),
        .overflow     (overflow),
        .words_pending(words_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            expq.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input int lim);
        int c;
        c = 0;
        while (busy && c < lim) begin
            tick;
            c++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Called on the cycle right after the pop edge: counts busy cycles.
    task automatic span(input string tag);
        int c;
        c = 1;
        while (busy && c < FRAME + 20) begin
            tick;
            if (busy) c++;
        end
        chk(tag, 32'(c), 32'(FRAME));
        chk({tag, "_tx"}, 32'(tx), 32'd1);
    endtask

    // UART decoder: mk counts cycles from the first low cycle of a frame.
    int         mk = -1;
    int         ms;
    logic [7:0] mb;

    always @(negedge clk) begin
        if (clr) begin
            mk = -1;
        end else if (mk < 0) begin
            if (tx === 1'b0) mk = 0;
        end else begin
            mk++;
            if (mk % CPB == CPB / 2) begin
                ms = mk / CPB;
                if (ms == 0) begin
                    chk("start_bit", 32'(tx), 32'd0);
                end else if (ms <= 8) begin
                    mb[ms-1] = tx;
`ifdef OUT_UART_PARITY_EN
                end else if (ms == 9) begin
                    chk("parity_bit", 32'(tx), 32'(^mb));
`endif
                end else begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    if (expq.size() == 0)
                        chk("unexpected_byte", 32'(mb), 32'h100);
                    else
                        chk("rx_byte", 32'(mb), 32'(expq.pop_front()));
                    mk = -1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1;
        tick;
        tick;
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("idle_state",
                32'({tx, busy, overflow, full, words_pending}), 32'h40);
        end

        // Single word
        out_wr = 1'b1;
        out_data = 32'h123456A5;
        push_word(out_data);
        tick;
        out_wr = 1'b0;
        chk("wp_after_wr", 32'(words_pending), 32'd1);
        chk("tx_before_pop", 32'(tx), 32'd1);
        chk("busy_after_wr", 32'(busy), 32'd1);
        tick;
        chk("tx_fall", 32'(tx), 32'd0);
        chk("wp_after_pop", 32'(words_pending), 32'd0);
        span("word_span");
        chk("q_empty_single", 32'(expq.size()), 32'd0);

        // Fill and overflow: occupancy runs 1,1,2,3,4
        for (int v = 1; v <= 5; v++) begin
            out_wr = 1'b1;
            out_data = 32'(v);
            push_word(out_data);
            tick;
            chk("fill_wp", 32'(words_pending), (v == 1) ? 32'd1 : 32'(v - 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        out_data = 32'd6;
        tick;
        out_wr = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_wp", 32'(words_pending), 32'd4);
        wait_idle(6 * (FRAME + 1) + 50);
        chk("q_empty_fill", 32'(expq.size()), 32'd0);

        // Simultaneous write and pop
        out_wr = 1'b1;
        out_data = 32'hCAFE0001;
        push_word(out_data);
        tick;
        out_data = 32'hBEEF0002;
        push_word(out_data);
        tick;
        out_wr = 1'b0;
        chk("sim_wp", 32'(words_pending), 32'd1);
        chk("sim_tx", 32'(tx), 32'd0);
        wait_idle(3 * (FRAME + 1) + 50);
        chk("q_empty_sim", 32'(expq.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during data bit 3 of byte 1
        out_wr = 1'b1;
        out_data = 32'hFFFF00FF;
        push_word(out_data);
        tick;
        out_wr = 1'b0;
        tick;
        chk("rst_start", 32'(tx), 32'd0);
        repeat (14 * CPB + 1) tick;
        chk("rst_bit3", 32'(tx), 32'd0);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        chk("rst_state",
            32'({tx, busy, overflow, full, words_pending}), 32'h40);
        chk("rst_q_left", 32'(expq.size()), 32'd3);
        expq.delete();
        out_wr = 1'b1;
        out_data = 32'h00000055;
        push_word(out_data);
        tick;
        out_wr = 1'b0;
        wait_idle(2 * FRAME + 50);
        chk("q_empty_rst", 32'(expq.size()), 32'd0);

        // Reset and write at the same edge: word discarded
        clr = 1'b1;
        out_wr = 1'b1;
        out_data = 32'hDEADBEEF;
        tick;
        clr = 1'b0;
        out_wr = 1'b0;
        chk("clr_wr_wp", 32'(words_pending), 32'd0);
        tick;
        tick;
        chk("clr_wr_idle", 32'({tx, busy}), 32'h2);

        // Parity pattern word
        out_wr = 1'b1;
        out_data = 32'h00000307;
        push_word(out_data);
        tick;
        out_wr = 1'b0;
        tick;
        chk("par_tx_fall", 32'(tx), 32'd0);
        span("par_span");
        chk("q_empty_par", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
